// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache controller and its SRAM.
// Contents: FSM state enum, field widths, address slice positions, and
// the bit positions of valid and dirty in the stored tag.
package dcache_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned LINE_W  = 256;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned TAG_W   = 23;
  localparam int unsigned STAG_W  = TAG_W + 2;   // {valid, dirty, tag}
  localparam int unsigned SETS    = 16;
  localparam int unsigned WAYS    = 2;
  localparam int unsigned WORDS   = LINE_W / WORD_W;
  localparam int unsigned WSEL_W  = 3;

  localparam int unsigned TAG_LSB  = 9;
  localparam int unsigned IDX_LSB  = 5;
  localparam int unsigned WORD_LSB = 2;

  localparam int unsigned VALID_BIT = 24;
  localparam int unsigned DIRTY_BIT = 23;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MISS    = 3'd1,
    S_WB      = 3'd2,
    S_FILL    = 3'd3,
    S_FILL_OK = 3'd4
  } state_e;

endpackage

// File: rtl/dcache_sram.sv
// 16-set, 2-way data-cache storage with one LRU bit per set.
// Lookup is combinational: returns hit, plus tag/data of the hit way, or of
// the LRU victim way on a miss. A write goes to the hit way if the tag
// matches, otherwise to the LRU victim way.
// Ports:
//   clk_i, rst_i      clock, async active-high reset (invalidates all tags)
//   idx_i             set index
//   tag_i             {valid, dirty, tag}; tag bits used for compare, all bits written
//   data_i            line to write
//   enable_i          CPU access (updates LRU on hit)
//   write_i           write tag_i/data_i into the selected way
//   hit_o, tag_o, data_o  lookup result
module dcache_sram
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [STAG_W-1:0] tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              hit_o,
  output logic [STAG_W-1:0] tag_o,
  output logic [LINE_W-1:0] data_o
);

  logic [STAG_W-1:0] tag_q  [SETS][WAYS];
  logic [LINE_W-1:0] data_q [SETS][WAYS];
  logic [SETS-1:0]   lru_q;               // way to evict next
  logic [WAYS-1:0]   way_hit;
  logic              sel_way;

  // Tag compare: valid line with matching tag.
  always_comb begin
    way_hit = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = tag_q[idx_i][w][VALID_BIT] &&
                   (tag_q[idx_i][w][TAG_W-1:0] == tag_i[TAG_W-1:0]);
    end
  end

  assign hit_o   = |way_hit;
  assign sel_way = way_hit[1] ? 1'b1 : (way_hit[0] ? 1'b0 : lru_q[idx_i]);
  assign tag_o   = tag_q[idx_i][sel_way];
  assign data_o  = data_q[idx_i][sel_way];

  // Tags and LRU; reset invalidates every line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
        end
      end
      lru_q <= '0;
    end else begin
      if (write_i) begin
        tag_q[idx_i][sel_way] <= tag_i;
      end
      if (write_i || (enable_i && hit_o)) begin
        lru_q[idx_i] <= ~sel_way;
      end
    end
  end

  // Line data needs no reset: it is only visible through a valid tag.
  always_ff @(posedge clk_i) begin
    if (write_i) begin
      data_q[idx_i][sel_way] <= data_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache controller: serves CPU word loads/stores from the cache SRAM
// in one cycle on a hit; on a miss stalls, writes back a dirty victim,
// refills the line from memory and replays the access.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   cpu_req_i, cpu_write_i  access request, 1=store
//   cpu_addr_i, cpu_data_i  byte address, store data
//   cpu_data_o, cpu_stall_o load data, pipeline stall (combinational)
//   mem_enable_o, mem_write_o, mem_addr_o, mem_data_o  line request to memory
//   mem_data_i, mem_ack_i   fetched line, completion pulse
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_write_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  state_e              state_q, state_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_data_q, mem_data_d;
  logic [LINE_W-1:0]   fill_line_q, fill_line_d;

  logic [TAG_W-1:0]    cpu_tag;
  logic [IDX_W-1:0]    cpu_idx;
  logic [WSEL_W-1:0]   cpu_word;
  logic [ADDR_W-1:0]   fetch_addr;
  logic                unused_addr_bits;

  logic                sram_enable, sram_write, sram_hit;
  logic [STAG_W-1:0]   sram_tag, sram_rtag;
  logic [LINE_W-1:0]   sram_wdata, sram_rdata;
  logic [WORD_W-1:0]   rd_word;
  logic [LINE_W-1:0]   merged_line;

  assign cpu_tag          = cpu_addr_i[ADDR_W-1:TAG_LSB];
  assign cpu_idx          = cpu_addr_i[TAG_LSB-1:IDX_LSB];
  assign cpu_word         = cpu_addr_i[IDX_LSB-1:WORD_LSB];
  assign fetch_addr       = {cpu_tag, cpu_idx, {IDX_LSB{1'b0}}};
  assign unused_addr_bits = ^cpu_addr_i[WORD_LSB-1:0];

  dcache_sram u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .idx_i    (cpu_idx),
    .tag_i    (sram_tag),
    .data_i   (sram_wdata),
    .enable_i (sram_enable),
    .write_i  (sram_write),
    .hit_o    (sram_hit),
    .tag_o    (sram_rtag),
    .data_o   (sram_rdata)
  );

  // Word select and store merge against the looked-up line.
  always_comb begin
    rd_word     = '0;
    merged_line = sram_rdata;
    for (int k = 0; k < WORDS; k++) begin
      if (cpu_word == WSEL_W'(k)) begin
        rd_word                         = sram_rdata[k*WORD_W +: WORD_W];
        merged_line[k*WORD_W +: WORD_W] = cpu_data_i;
      end
    end
  end

  // Next-state, memory request and SRAM control.
  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    fill_line_d  = fill_line_q;
    sram_enable  = 1'b0;
    sram_write   = 1'b0;
    sram_tag     = {1'b1, 1'b0, cpu_tag};
    sram_wdata   = sram_rdata;
    cpu_stall_o  = 1'b1;
    cpu_data_o   = '0;

    unique case (state_q)
      S_IDLE: begin
        cpu_stall_o = 1'b0;
        if (cpu_req_i) begin
          sram_enable = 1'b1;
          if (sram_hit) begin
            cpu_data_o = rd_word;
            if (cpu_write_i) begin
              sram_write = 1'b1;
              sram_tag   = {1'b1, 1'b1, cpu_tag};
              sram_wdata = merged_line;
            end
          end else begin
            cpu_stall_o = 1'b1;
            state_d     = S_MISS;
          end
        end
      end
      S_MISS: begin
        // Lookup misses here, so sram_rtag/sram_rdata are the LRU victim.
        mem_enable_d = 1'b1;
        if (sram_rtag[VALID_BIT] && sram_rtag[DIRTY_BIT]) begin
          mem_write_d = 1'b1;
          mem_addr_d  = {sram_rtag[TAG_W-1:0], cpu_idx, {IDX_LSB{1'b0}}};
          mem_data_d  = sram_rdata;
          state_d     = S_WB;
        end else begin
          mem_write_d = 1'b0;
          mem_addr_d  = fetch_addr;
          state_d     = S_FILL;
        end
      end
      S_WB: begin
        if (mem_ack_i) begin
          mem_write_d = 1'b0;
          mem_addr_d  = fetch_addr;
          state_d     = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_ack_i) begin
          fill_line_d  = mem_data_i;
          mem_enable_d = 1'b0;
          state_d      = S_FILL_OK;
        end
      end
      S_FILL_OK: begin
        sram_write = 1'b1;
        sram_tag   = {1'b1, 1'b0, cpu_tag};
        sram_wdata = fill_line_q;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and memory-interface registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      fill_line_q  <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      fill_line_q  <= fill_line_d;
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

endmodule
